axis_counter_scheduler: RTL and testbench

- Sequences a downstream stop-mode AXI-Stream ramp counter through queued bursts.
- Burst descriptors arrive on an AXI-Stream slave. Each descriptor carries the last ramp value, an inter-burst gap and a repeat count.
- The block drives the counter's cfg_data and its synchronous reset. It taps the counter's output handshake to detect the end of each burst.
- It sits between a DMA/config FIFO and the counter, in the same aclk domain.

---
 rtl/axis_counter_scheduler.sv | 155 +++++++++++++++
 tb/tb_axis_counter_scheduler.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_counter_scheduler.sv
// Drives a stop-mode AXI-Stream ramp counter through queued bursts: each accepted
// descriptor yields R+1 bursts of 0..V separated by max(G,1) cycles of counter reset.
module axis_counter_scheduler #(
  parameter int AXIS_TDATA_WIDTH   = 32,
  parameter int S_AXIS_TDATA_WIDTH = 64,
  parameter int CNTR_WIDTH         = 32,
  parameter int GAP_WIDTH          = 16,
  parameter int REP_WIDTH          = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]   mon_tdata,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  output logic                          cntr_aresetn,
  output logic [CNTR_WIDTH-1:0]         cntr_cfg_data,
  output logic                          sts_busy,
  output logic                          sts_done,
  output logic [31:0]                   sts_bursts
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t                  state_q, state_d;
  logic                    s_tready_q, s_tready_d;
  logic                    cntr_aresetn_q, cntr_aresetn_d;
  logic [CNTR_WIDTH-1:0]   cfg_q, cfg_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [31:0]             bursts_q, bursts_d;
  logic [GAP_WIDTH-1:0]    gap_cnt_q, gap_cnt_d;
  logic [GAP_WIDTH-1:0]    gap_len_q, gap_len_d;
  logic [REP_WIDTH-1:0]    rep_cnt_q, rep_cnt_d;

  logic [CNTR_WIDTH-1:0]   desc_v;
  logic [GAP_WIDTH-1:0]    desc_g;
  logic [GAP_WIDTH-1:0]    desc_gap;
  logic [REP_WIDTH-1:0]    desc_r;
  logic                    burst_end;

  // Fields not consumed by the scheduler are folded into a deliberately unused net.
  logic unused_upper_bits;
  assign unused_upper_bits = ^{s_axis_tdata, mon_tdata};

  assign desc_v   = s_axis_tdata[CNTR_WIDTH-1:0];
  assign desc_g   = s_axis_tdata[CNTR_WIDTH +: GAP_WIDTH];
  assign desc_r   = s_axis_tdata[CNTR_WIDTH+GAP_WIDTH +: REP_WIDTH];
  assign desc_gap = (desc_g == '0) ? GAP_WIDTH'(1) : desc_g;

  assign burst_end = mon_tvalid && mon_tready && (mon_tdata[CNTR_WIDTH-1:0] == cfg_q);

  always_comb begin
    state_d        = state_q;
    s_tready_d     = s_tready_q;
    cntr_aresetn_d = cntr_aresetn_q;
    cfg_d          = cfg_q;
    done_d         = 1'b0;
    bursts_d       = bursts_q;
    gap_cnt_d      = gap_cnt_q;
    gap_len_d      = gap_len_q;
    rep_cnt_d      = rep_cnt_q;

    unique case (state_q)
      IDLE: begin
        s_tready_d     = 1'b1;
        cntr_aresetn_d = 1'b0;
        if (s_axis_tvalid && s_tready_q) begin
          s_tready_d = 1'b0;
          cfg_d      = desc_v;
          gap_cnt_d  = desc_gap;
          gap_len_d  = desc_gap;
          rep_cnt_d  = desc_r;
          if (desc_v != '0) begin
            state_d        = RUN;
            cntr_aresetn_d = 1'b1;
          end else begin
            state_d  = GAP;
            bursts_d = bursts_q + 32'd1;
          end
        end
      end

      RUN: begin
        if (burst_end) begin
          state_d        = GAP;
          cntr_aresetn_d = 1'b0;
          bursts_d       = bursts_q + 32'd1;
        end
      end

      GAP: begin
        if (gap_cnt_q <= GAP_WIDTH'(1)) begin
          gap_cnt_d = gap_len_q;
          if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - REP_WIDTH'(1);
            // A zero-length burst never releases the counter; it just counts and re-gaps.
            if (cfg_q != '0) begin
              state_d        = RUN;
              cntr_aresetn_d = 1'b1;
            end else begin
              bursts_d = bursts_q + 32'd1;
            end
          end else begin
            state_d    = IDLE;
            done_d     = 1'b1;
            s_tready_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      s_tready_q     <= 1'b0;
      cntr_aresetn_q <= 1'b0;
      cfg_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      bursts_q       <= '0;
      gap_cnt_q      <= '0;
      gap_len_q      <= '0;
      rep_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      s_tready_q     <= s_tready_d;
      cntr_aresetn_q <= cntr_aresetn_d;
      cfg_q          <= cfg_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      bursts_q       <= bursts_d;
      gap_cnt_q      <= gap_cnt_d;
      gap_len_q      <= gap_len_d;
      rep_cnt_q      <= rep_cnt_d;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign cntr_aresetn  = cntr_aresetn_q;
  assign cntr_cfg_data = cfg_q;
  assign sts_busy      = busy_q;
  assign sts_done      = done_q;
  assign sts_bursts    = bursts_q;

endmodule

// File: tb/tb_axis_counter_scheduler.sv
// Directed bench for axis_counter_scheduler with a behavioural stop-mode ramp counter
// hanging off cntr_aresetn / cntr_cfg_data and feeding the mon_* tap.
module tb_axis_counter_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        cntr_aresetn;
  logic [31:0] cntr_cfg_data;
  logic        sts_busy;
  logic        sts_done;
  logic [31:0] sts_bursts;

  logic [31:0] m_data    = '0;
  logic        m_valid   = 1'b0;
  logic        m_stopped = 1'b0;
  logic        cnt_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] beats[$];
  logic [31:0] low_runs[$];
  logic [31:0] exp_q[$];
  int          run_len = 0;
  int          done_cnt = 0;
  int          hi_cnt = 0;

  always #5 aclk = ~aclk;

  axis_counter_scheduler dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .mon_tdata     (m_data),
    .mon_tvalid    (m_valid),
    .mon_tready    (cnt_ready),
    .cntr_aresetn  (cntr_aresetn),
    .cntr_cfg_data (cntr_cfg_data),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_bursts    (sts_bursts)
  );

  // Stop-mode counter: after release emits 0..cfg once, then idles until reset.
  always @(posedge aclk) begin
    if (!cntr_aresetn) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_stopped <= 1'b0;
    end else if (!m_stopped) begin
      if (!m_valid) begin
        if (cntr_cfg_data != 0) m_valid <= 1'b1;
        m_data <= '0;
      end else if (cnt_ready) begin
        if (m_data == cntr_cfg_data) begin
          m_valid   <= 1'b0;
          m_stopped <= 1'b1;
        end else begin
          m_data <= m_data + 32'd1;
        end
      end
    end
  end

  // Observation: accepted beats, done pulses, and lengths of busy counter-reset runs.
  always @(posedge aclk) begin
    if (m_valid && cnt_ready) beats.push_back(m_data);
    if (sts_done === 1'b1) done_cnt++;
    if (cntr_aresetn === 1'b1) hi_cnt++;
    if (sts_busy === 1'b1 && cntr_aresetn === 1'b0) run_len++;
    else if (run_len != 0) begin
      low_runs.push_back(32'(run_len));
      run_len = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit queue_eq(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void add_ramp(input int v, input int reps);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k <= v; k++) exp_q.push_back(32'(k));
  endfunction

  task automatic clear_obs();
    beats.delete();
    low_runs.delete();
    exp_q.delete();
    done_cnt = 0;
    hi_cnt   = 0;
  endtask

  task automatic send_desc(input logic [31:0] v, input logic [15:0] g, input logic [7:0] r);
    bit acc  = 1'b0;
    bit will = 1'b0;
    s_axis_tdata  = {8'hA5, r, g, v};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      will = s_axis_tready;
      @(negedge aclk);
      acc = will;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL desc_accept: accepted=%0d, required 1", acc);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    bit idle = 1'b0;
    for (int i = 0; i < max_cycles && !idle; i++) begin
      @(negedge aclk);
      idle = (sts_busy === 1'b0);
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", sts_busy, max_cycles);
    end
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    cnt_ready     = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_axis_tready, cntr_aresetn, sts_busy, sts_done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 0000",
               {s_axis_tready, cntr_aresetn, sts_busy, sts_done});
    end
    checks++;
    if (cntr_cfg_data !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_cfg: got %0d, required 0", cntr_cfg_data);
    end
    checks++;
    if (sts_bursts !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_bursts: got %0d, required 0", sts_bursts);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1 || sts_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: tready=%b busy=%b, required 1 0", s_axis_tready, sts_busy);
    end
  endtask

  task automatic test_single_burst();
    clear_obs();
    send_desc(32'd3, 16'd0, 8'd0);
    checks++;
    if ({s_axis_tready, cntr_aresetn, sts_busy} !== 3'b011 || cntr_cfg_data !== 32'd3) begin
      errors++;
      $display("[TB] FAIL single_accept: tready/rstn/busy=%b cfg=%0d, required 011 3",
               {s_axis_tready, cntr_aresetn, sts_busy}, cntr_cfg_data);
    end
    wait_idle(100);
    add_ramp(3, 1);
    checks++;
    if (!queue_eq(beats, exp_q)) begin
      errors++;
      $display("[TB] FAIL single_beats: got %0d beats, required %0d", beats.size(), exp_q.size());
    end
    checks++;
    if (!queue_eq(low_runs, '{32'd1})) begin
      errors++;
      $display("[TB] FAIL single_gap: got %0d runs (first=%0d), required 1 run of 1",
               low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : 0);
    end
    checks++;
    if (done_cnt != 1 || sts_bursts !== 32'd1 || s_axis_tready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_status: done=%0d bursts=%0d tready=%b, required 1 1 1",
               done_cnt, sts_bursts, s_axis_tready);
    end
  endtask

  task automatic test_repeat_gap();
    logic [31:0] b0;
    clear_obs();
    b0 = sts_bursts;
    send_desc(32'd2, 16'd5, 8'd2);
    wait_idle(200);
    add_ramp(2, 3);
    checks++;
    if (!queue_eq(beats, exp_q)) begin
      errors++;
      $display("[TB] FAIL repeat_beats: got %0d beats, required %0d", beats.size(), exp_q.size());
    end
    checks++;
    if (!queue_eq(low_runs, '{32'd5, 32'd5, 32'd5})) begin
      errors++;
      $display("[TB] FAIL repeat_gaps: got %0d runs (first=%0d), required 3 runs of 5",
               low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : 0);
    end
    checks++;
    if (done_cnt != 1 || sts_bursts !== b0 + 32'd3) begin
      errors++;
      $display("[TB] FAIL repeat_status: done=%0d bursts=%0d, required 1 %0d",
               done_cnt, sts_bursts, b0 + 32'd3);
    end
  endtask

  task automatic test_zero_beat();
    logic [31:0] b0;
    clear_obs();
    b0 = sts_bursts;
    send_desc(32'd0, 16'd4, 8'd1);
    checks++;
    if ({s_axis_tready, cntr_aresetn, sts_busy} !== 3'b001 || sts_bursts !== b0 + 32'd1) begin
      errors++;
      $display("[TB] FAIL zero_accept: tready/rstn/busy=%b bursts=%0d, required 001 %0d",
               {s_axis_tready, cntr_aresetn, sts_busy}, sts_bursts, b0 + 32'd1);
    end
    wait_idle(100);
    checks++;
    if (!queue_eq(low_runs, '{32'd8}) || hi_cnt != 0 || beats.size() != 0) begin
      errors++;
      $display("[TB] FAIL zero_hold: runs=%0d first=%0d high=%0d beats=%0d, required 1 8 0 0",
               low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : 0, hi_cnt, beats.size());
    end
    checks++;
    if (done_cnt != 1 || sts_bursts !== b0 + 32'd2) begin
      errors++;
      $display("[TB] FAIL zero_status: done=%0d bursts=%0d, required 1 %0d",
               done_cnt, sts_bursts, b0 + 32'd2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] b0;
    logic [7:0]  pat = 8'b1011_0100;
    bit          stalled = 1'b0;
    int          viol = 0;
    clear_obs();
    b0 = sts_bursts;
    send_desc(32'd4, 16'd2, 8'd0);
    for (int i = 0; i < 200 && sts_busy === 1'b1; i++) begin
      if (!stalled && m_valid && m_data == 32'd4) begin
        cnt_ready = 1'b0;
        repeat (3) begin
          @(negedge aclk);
          if (sts_busy !== 1'b1 || cntr_aresetn !== 1'b1) viol++;
        end
        stalled = 1'b1;
      end else begin
        cnt_ready = pat[i % 8];
      end
      @(negedge aclk);
    end
    cnt_ready = 1'b1;
    wait_idle(100);
    checks++;
    if (!stalled || viol != 0) begin
      errors++;
      $display("[TB] FAIL stall_hold: stalled=%0d early_exit_cycles=%0d, required 1 0", stalled, viol);
    end
    add_ramp(4, 1);
    checks++;
    if (!queue_eq(beats, exp_q) || !queue_eq(low_runs, '{32'd2})) begin
      errors++;
      $display("[TB] FAIL stall_beats: beats=%0d runs=%0d, required %0d 1",
               beats.size(), low_runs.size(), exp_q.size());
    end
    checks++;
    if (done_cnt != 1 || sts_bursts !== b0 + 32'd1) begin
      errors++;
      $display("[TB] FAIL stall_status: done=%0d bursts=%0d, required 1 %0d",
               done_cnt, sts_bursts, b0 + 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b0;
    bit          saw = 1'b0;
    logic        done_at = 1'b0;
    logic        busy_at = 1'b1;
    clear_obs();
    b0 = sts_bursts;
    send_desc(32'd2, 16'd3, 8'd0);
    s_axis_tdata  = {8'h5A, 8'd0, 16'd1, 32'd1};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100 && !saw; i++) begin
      if (s_axis_tready === 1'b1) begin
        saw     = 1'b1;
        done_at = sts_done;
        busy_at = sts_busy;
      end else begin
        @(negedge aclk);
      end
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    checks++;
    if (!saw || done_at !== 1'b1 || busy_at !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_window: seen=%0d done=%b busy=%b, required 1 1 0", saw, done_at, busy_at);
    end
    checks++;
    if ({s_axis_tready, cntr_aresetn, sts_busy} !== 3'b011 || cntr_cfg_data !== 32'd1) begin
      errors++;
      $display("[TB] FAIL b2b_accept: tready/rstn/busy=%b cfg=%0d, required 011 1",
               {s_axis_tready, cntr_aresetn, sts_busy}, cntr_cfg_data);
    end
    wait_idle(100);
    add_ramp(2, 1);
    add_ramp(1, 1);
    checks++;
    if (!queue_eq(beats, exp_q) || !queue_eq(low_runs, '{32'd3, 32'd1})) begin
      errors++;
      $display("[TB] FAIL b2b_beats: beats=%0d runs=%0d, required %0d 2",
               beats.size(), low_runs.size(), exp_q.size());
    end
    checks++;
    if (done_cnt != 2 || sts_bursts !== b0 + 32'd2) begin
      errors++;
      $display("[TB] FAIL b2b_status: done=%0d bursts=%0d, required 2 %0d",
               done_cnt, sts_bursts, b0 + 32'd2);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit found = 1'b0;
    send_desc(32'd7, 16'd1, 8'd0);
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_valid && m_data == 32'd2) found = 1'b1;
      else @(negedge aclk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL midrst_reach: value 2 seen=%0d, required 1", found);
    end
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    checks++;
    if ({s_axis_tready, cntr_aresetn, sts_busy, sts_done} !== 4'b0000 ||
        cntr_cfg_data !== 32'd0 || sts_bursts !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrst_values: flags=%b cfg=%0d bursts=%0d, required 0000 0 0",
               {s_axis_tready, cntr_aresetn, sts_busy, sts_done}, cntr_cfg_data, sts_bursts);
    end
    @(negedge aclk);
    checks++;
    if (s_axis_tready !== 1'b1 || cntr_aresetn !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_hold: tready=%b rstn=%b cnt_valid=%b, required 1 0 0",
               s_axis_tready, cntr_aresetn, m_valid);
    end
    clear_obs();
    send_desc(32'd2, 16'd0, 8'd0);
    wait_idle(100);
    add_ramp(2, 1);
    checks++;
    if (!queue_eq(beats, exp_q) || sts_bursts !== 32'd1 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL midrst_rerun: beats=%0d bursts=%0d done=%0d, required %0d 1 1",
               beats.size(), sts_bursts, done_cnt, exp_q.size());
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_burst();
    test_repeat_gap();
    test_zero_beat();
    test_stall();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
